fp_regfile_mp: RTL and testbench
================================

// Module: fp_regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the FP/GPR datapath: NREAD
//  synchronous read ports, two write ports, and optional same-cycle write-to-read
//  bypass. A built-in sequential scrubber zeroes every entry after reset or on
//  CLEAR, so the file never returns X.
//  Sits between decode (read addresses) and writeback (two write ports).
// PARAMETERS
//  WIDTH      64  data width in bits
//  ADDR_BITS  6   address width; DEPTH = 2**ADDR_BITS entries
//  NREAD      3   number of read ports (>=1)
//  BYPASS     1   1: a same-cycle write is forwarded to a matching read; 0: the read returns the old value
// PORTS
//  CLK    in   1                  clock, all state updates on posedge
//  RST_N  in   1                  asynchronous, active-low reset
//  R      in   NREAD*ADDR_BITS    read addresses; port k = R[k*ADDR_BITS +: ADDR_BITS]
//  D      out  NREAD*WIDTH        registered read data; port k = D[k*WIDTH +: WIDTH]
//  WE0    in   1                  write enable, port 0
//  RW0    in   ADDR_BITS          write address, port 0
//  DW0    in   WIDTH              write data, port 0
//  WE1    in   1                  write enable, port 1
//  RW1    in   ADDR_BITS          write address, port 1
//  DW1    in   WIDTH              write data, port 1
//  CLEAR  in   1                  request a full scrub (sampled only in READY)
//  BUSY   out  1                  high while scrubbing; writes are ignored and D reads as 0
// BEHAVIOUR
//  - Reset (RST_N=0, async): D=0, BUSY=1, FSM=SCRUB, scrub counter=0. Array
//    contents are not reset directly; the scrubber clears them.
//  - FSM states: SCRUB and READY.
//    - SCRUB: each cycle writes 0 to entry[cnt], then cnt++. While cnt==DEPTH-1,
//      the last entry is written and the next state is READY. BUSY=0 from the
//      following cycle, so scrub takes exactly DEPTH cycles after reset release.
//    - READY: CLEAR=1 sets cnt=0 and moves to SCRUB next cycle. BUSY rises one
//      cycle after CLEAR is sampled. Writes presented in the same cycle as
//      CLEAR still commit, then are scrubbed.
//    - CLEAR in SCRUB is ignored; scrubbing neither restarts nor extends.
//  - Write: in READY, WEn=1 writes DWn to entry[RWn] at posedge.
//    - WE0 and WE1 to the same address: port 1 wins.
//    - In SCRUB, WE0 and WE1 are ignored, including the final scrub cycle.
//  - Read: read latency is 1 cycle. In READY, D_k <= entry[R_k] at posedge.
//    - BYPASS=1: if R_k matches an enabled write address in that cycle, D_k
//      takes the written data. Port 1 has priority over port 0.
//    - BYPASS=0: D_k gets the pre-write contents.
//    - Multiple read ports may read the same address; each gets an identical value.
//  - In SCRUB, D_k <= 0 every cycle. The first READY-cycle read appears on D
//    one cycle after BUSY falls.
//  - Reset asserted mid-scrub or mid-write: all state returns to reset values
//    immediately and the scrub restarts at entry 0 on release. A write in the
//    reset-edge cycle is lost.
//  - Address arithmetic: cnt is ADDR_BITS+1 wide internally. No wrap: the
//    terminal count is detected explicitly.
// TESTING
//  1. Release RST_N and count cycles -> BUSY=1 for exactly 64 cycles, then 0.
//     Read all 64 entries -> every D_k = 0.
//  2. WE0=1, RW0=5, DW0=64'hDEAD_BEEF_0123_4567; next cycle R_0=5 -> D_0 equals
//     that value one cycle later. D_1 and D_2 at addresses 6 and 7 read 0.
//  3. Same cycle: WE0 and WE1 both to RW=9 (DW0=1, DW1=2) and R_0=9, BYPASS=1
//     -> D_0=2 next cycle, and entry 9 reads 2 afterwards.
//     With BYPASS=0 -> D_0=0 next cycle, then 2 on re-read.
//  4. Fill entries 0..63 with index values, then pulse CLEAR with WE0 to entry 3
//     -> BUSY=1 for 64 cycles, writes during BUSY are ignored, and all entries
//     read 0 afterwards.
//  5. Drop RST_N at scrub cycle 20, hold 3 cycles, release -> D=0 and BUSY=1
//     throughout. BUSY falls exactly 64 cycles after release.
//  6. Parametrisation: WIDTH=32, ADDR_BITS=5, NREAD=4 -> scrub takes 32 cycles.
//     All 4 read ports return the correct data for random write/read traffic
//     checked against a reference model.

Source files
------------

// File: rtl/fp_regfile_mp.sv
// Multi-port register file: NREAD registered read ports, two write ports, optional
// same-cycle write-to-read bypass, and a sequential scrubber that zeroes every entry.
module fp_regfile_mp #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 6,
  parameter int NREAD     = 3,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NREAD*ADDR_BITS-1:0] R,
  output logic [NREAD*WIDTH-1:0]     D,
  input  logic                       WE0,
  input  logic [ADDR_BITS-1:0]       RW0,
  input  logic [WIDTH-1:0]           DW0,
  input  logic                       WE1,
  input  logic [ADDR_BITS-1:0]       RW1,
  input  logic [WIDTH-1:0]           DW1,
  input  logic                       CLEAR,
  output logic                       BUSY
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_LAST = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [ADDR_BITS:0] CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic {SCRUB = 1'b0, READY = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_BITS:0]          cnt, cnt_nxt;
  logic [WIDTH-1:0]            mem [DEPTH];
  logic [ADDR_BITS-1:0]        ra;
  logic [NREAD-1:0][WIDTH-1:0] rd_p0;
  logic [NREAD-1:0][WIDTH-1:0] d_p1;
  logic                        ready;

  assign ready = (state == READY);
  assign BUSY  = ~ready;
  assign D     = d_p1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SCRUB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SCRUB: begin
        if (cnt == CNT_LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      READY: begin
        if (CLEAR) begin
          state_nxt = SCRUB;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = SCRUB;
    endcase
  end

  // Scrub owns the array while busy; port 1 is applied last so it wins a collision.
  always_ff @(posedge CLK) begin
    if (!ready) begin
      mem[cnt[ADDR_BITS-1:0]] <= '0;
    end else begin
      if (WE0) mem[RW0] <= DW0;
      if (WE1) mem[RW1] <= DW1;
    end
  end

  // Stage p0: array lookup with optional forwarding of this cycle's writes
  always_comb begin
    rd_p0 = '0;
    ra    = '0;
    for (int k = 0; k < NREAD; k++) begin
      ra       = R[k*ADDR_BITS +: ADDR_BITS];
      rd_p0[k] = mem[ra];
      if (BYPASS && WE0 && (RW0 == ra)) rd_p0[k] = DW0;
      if (BYPASS && WE1 && (RW1 == ra)) rd_p0[k] = DW1;
    end
  end

  // Stage p1: registered read data, forced to zero while scrubbing
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_p1 <= '0;
    end else if (!ready) begin
      d_p1 <= '0;
    end else begin
      d_p1 <= rd_p0;
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Bench for fp_regfile_mp: default-sized instances with and without bypass plus a
// 32-bit/5-bit/4-port instance, checked against an array-based reference model.
module tb_fp_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [17:0]  r_ab;
  logic [191:0] d_a, d_b;
  logic         we0, we1, clear, busy_a, busy_b;
  logic [5:0]   rw0, rw1;
  logic [63:0]  dw0, dw1;

  logic [19:0]  r_c;
  logic [127:0] d_c;
  logic         c_we0, c_we1, c_clear, busy_c;
  logic [4:0]   c_rw0, c_rw1;
  logic [31:0]  c_dw0, c_dw1;

  int vecs = 0;
  int errs = 0;

  fp_regfile_mp dut_a (
    .CLK(clk), .RST_N(rst_n), .R(r_ab), .D(d_a),
    .WE0(we0), .RW0(rw0), .DW0(dw0), .WE1(we1), .RW1(rw1), .DW1(dw1),
    .CLEAR(clear), .BUSY(busy_a));

  fp_regfile_mp #(.BYPASS(1'b0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .R(r_ab), .D(d_b),
    .WE0(we0), .RW0(rw0), .DW0(dw0), .WE1(we1), .RW1(rw1), .DW1(dw1),
    .CLEAR(clear), .BUSY(busy_b));

  fp_regfile_mp #(.WIDTH(32), .ADDR_BITS(5), .NREAD(4), .BYPASS(1'b1)) dut_c (
    .CLK(clk), .RST_N(rst_n), .R(r_c), .D(d_c),
    .WE0(c_we0), .RW0(c_rw0), .DW0(c_dw0), .WE1(c_we1), .RW1(c_rw1), .DW1(c_dw1),
    .CLEAR(c_clear), .BUSY(busy_c));

  // Reference model: plain arrays plus "scrub cycles still to go" counters
  logic [63:0]  m_ab [64];
  logic [31:0]  m_c  [32];
  int           sl_ab, sl_c;
  logic [191:0] exp_da, exp_db;
  logic [127:0] exp_dc;

  task automatic model_reset();
    sl_ab  = 64;
    sl_c   = 32;
    exp_da = '0;
    exp_db = '0;
    exp_dc = '0;
  endtask

  task automatic model_step();
    logic [5:0]  a;
    logic [4:0]  ac;
    logic [63:0] old, fwd;
    logic [31:0] oldc, fwdc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sl_ab > 0) begin
      exp_da = '0;
      exp_db = '0;
      sl_ab--;
      if (sl_ab == 0) foreach (m_ab[i]) m_ab[i] = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        a   = r_ab[k*6 +: 6];
        old = m_ab[a];
        fwd = old;
        if (we0 && rw0 == a) fwd = dw0;
        if (we1 && rw1 == a) fwd = dw1;
        exp_da[k*64 +: 64] = fwd;
        exp_db[k*64 +: 64] = old;
      end
      if (we0) m_ab[rw0] = dw0;
      if (we1) m_ab[rw1] = dw1;
      if (clear) sl_ab = 64;
    end
    if (sl_c > 0) begin
      exp_dc = '0;
      sl_c--;
      if (sl_c == 0) foreach (m_c[i]) m_c[i] = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        ac   = r_c[k*5 +: 5];
        oldc = m_c[ac];
        fwdc = oldc;
        if (c_we0 && c_rw0 == ac) fwdc = c_dw0;
        if (c_we1 && c_rw1 == ac) fwdc = c_dw1;
        exp_dc[k*32 +: 32] = fwdc;
      end
      if (c_we0) m_c[c_rw0] = c_dw0;
      if (c_we1) m_c[c_rw1] = c_dw1;
      if (c_clear) sl_c = 32;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; clear = 1'b0;
    rw0 = '0; rw1 = '0; dw0 = '0; dw1 = '0;
    c_we0 = 1'b0; c_we1 = 1'b0; c_clear = 1'b0;
    c_rw0 = '0; c_rw1 = '0; c_dw0 = '0; c_dw1 = '0;
  endtask

  task automatic test_reset();
    int n_a, n_c;
    idle_inputs();
    r_ab = '0;
    r_c  = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    vecs++; if (busy_a !== 1'b1 || busy_c !== 1'b1)
      begin errs++; $display("FAIL reset_busy: got a=%b c=%b want 1", busy_a, busy_c); end
    vecs++; if (d_a !== '0 || d_c !== '0)
      begin errs++; $display("FAIL reset_d: got a=%h c=%h want 0", d_a, d_c); end
    rst_n = 1'b1;
    n_a = 0;
    n_c = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (n_a == 0 && busy_a === 1'b0) n_a = i;
      if (n_c == 0 && busy_c === 1'b0) n_c = i;
      if (n_a != 0 && n_c != 0) break;
    end
    vecs++; if (n_a != 64) begin errs++; $display("FAIL scrub_len_a: got %0d want 64", n_a); end
    vecs++; if (n_c != 32) begin errs++; $display("FAIL scrub_len_c: got %0d want 32", n_c); end
    for (int i = 0; i < 22; i++) begin
      r_ab = {6'((i + 42) % 64), 6'((i + 21) % 64), 6'(i)};
      r_c  = {5'((i + 24) % 32), 5'((i + 16) % 32), 5'((i + 8) % 32), 5'(i)};
      tick();
      vecs++; if (d_a !== '0 || d_c !== '0)
        begin errs++; $display("FAIL scrubbed_read i=%0d: got a=%h c=%h want 0", i, d_a, d_c); end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    we0 = 1'b1; rw0 = 6'd5; dw0 = 64'hDEAD_BEEF_0123_4567;
    r_ab = '0;
    tick();
    we0 = 1'b0;
    r_ab = {6'd7, 6'd6, 6'd5};
    tick();
    vecs++; if (d_a[63:0] !== 64'hDEAD_BEEF_0123_4567)
      begin errs++; $display("FAIL wr_rd_p0: got %h want deadbeef01234567", d_a[63:0]); end
    vecs++; if (d_a[191:64] !== '0)
      begin errs++; $display("FAIL wr_rd_p12: got %h want 0", d_a[191:64]); end
    vecs++; if (d_b !== exp_db)
      begin errs++; $display("FAIL wr_rd_nobyp: got %h want %h", d_b, exp_db); end
  endtask

  task automatic test_same_addr();
    idle_inputs();
    we0 = 1'b1; rw0 = 6'd9; dw0 = 64'd1;
    we1 = 1'b1; rw1 = 6'd9; dw1 = 64'd2;
    r_ab = {6'd9, 6'd9, 6'd9};
    tick();
    idle_inputs();
    vecs++; if (d_a !== {3{64'd2}})
      begin errs++; $display("FAIL bypass_prio: got %h want all 2", d_a); end
    vecs++; if (d_b[63:0] !== 64'd0)
      begin errs++; $display("FAIL nobypass_old: got %h want 0", d_b[63:0]); end
    tick();
    vecs++; if (d_a[63:0] !== 64'd2 || d_b[63:0] !== 64'd2)
      begin errs++; $display("FAIL collide_reread: got a=%h b=%h want 2", d_a[63:0], d_b[63:0]); end
  endtask

  task automatic test_clear();
    int n;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      we0 = 1'b1; rw0 = 6'(2*i);     dw0 = 64'(2*i);
      we1 = 1'b1; rw1 = 6'(2*i + 1); dw1 = 64'(2*i + 1);
      tick();
    end
    idle_inputs();
    r_ab = {6'd63, 6'd3, 6'd0};
    tick();
    vecs++; if (d_a !== {64'd63, 64'd3, 64'd0} || d_b !== {64'd63, 64'd3, 64'd0})
      begin errs++; $display("FAIL fill_readback: got a=%h b=%h", d_a, d_b); end
    we0 = 1'b1; rw0 = 6'd3; dw0 = 64'h77;
    clear = 1'b1;
    tick();
    idle_inputs();
    vecs++; if (busy_a !== 1'b1 || busy_b !== 1'b1)
      begin errs++; $display("FAIL clear_busy_rise: got a=%b b=%b want 1", busy_a, busy_b); end
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      we0 = 1'b1; rw0 = 6'($urandom_range(63, 0)); dw0 = {$urandom, $urandom};
      we1 = 1'b1; rw1 = 6'($urandom_range(63, 0)); dw1 = {$urandom, $urandom};
      clear = 1'($urandom_range(1, 0));
      r_ab = 18'($urandom);
      tick();
      vecs++; if (d_a !== '0 || d_b !== '0)
        begin errs++; $display("FAIL clear_d_zero i=%0d: got a=%h b=%h", i, d_a, d_b); end
      if (busy_a === 1'b0) begin
        n = i;
        break;
      end
    end
    idle_inputs();
    vecs++; if (n != 64) begin errs++; $display("FAIL clear_len: got %0d want 64", n); end
    for (int i = 0; i < 22; i++) begin
      r_ab = {6'((i + 42) % 64), 6'((i + 21) % 64), 6'(i)};
      tick();
      vecs++; if (d_a !== '0 || d_b !== '0)
        begin errs++; $display("FAIL post_clear i=%0d: got a=%h b=%h want 0", i, d_a, d_b); end
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    idle_inputs();
    we0 = 1'b1; rw0 = 6'd10; dw0 = 64'h0123_4567_89AB_CDEF;
    tick();
    we0 = 1'b0;
    r_ab = {6'd10, 6'd10, 6'd10};
    tick();
    vecs++; if (d_a[63:0] !== 64'h0123_4567_89AB_CDEF)
      begin errs++; $display("FAIL pre_reset_read: got %h", d_a[63:0]); end
    we0 = 1'b1; rw0 = 6'd11; dw0 = 64'h55;
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++; if (d_a !== '0 || busy_a !== 1'b1)
      begin errs++; $display("FAIL async_reset: got d=%h busy=%b want 0/1", d_a, busy_a); end
    repeat (3) tick();
    we0 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    vecs++; if (busy_a !== 1'b1)
      begin errs++; $display("FAIL mid_scrub_busy: got %b want 1", busy_a); end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (d_a !== '0 || busy_a !== 1'b1 || busy_c !== 1'b1)
        begin errs++; $display("FAIL hold_reset i=%0d: got d=%h busy=%b", i, d_a, busy_a); end
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (busy_a === 1'b0) begin
        n = i;
        break;
      end
    end
    vecs++; if (n != 64) begin errs++; $display("FAIL rescrub_len: got %0d want 64", n); end
    r_ab = {6'd11, 6'd10, 6'd11};
    tick();
    vecs++; if (d_a !== '0)
      begin errs++; $display("FAIL after_reset_read: got %h want 0", d_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      rw0 = ($urandom_range(1, 0) != 0) ? 6'($urandom_range(7, 0)) : 6'($urandom);
      rw1 = ($urandom_range(1, 0) != 0) ? 6'($urandom_range(7, 0)) : 6'($urandom);
      dw0 = {$urandom, $urandom};
      dw1 = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) r_ab[k*6 +: 6] = 6'($urandom_range(7, 0));
      clear = ($urandom_range(79, 0) == 0);
      c_we0 = 1'($urandom); c_we1 = 1'($urandom);
      c_rw0 = 5'($urandom_range(7, 0)); c_rw1 = 5'($urandom_range(7, 0));
      c_dw0 = $urandom; c_dw1 = $urandom;
      for (int k = 0; k < 4; k++) r_c[k*5 +: 5] = 5'($urandom_range(7, 0));
      c_clear = ($urandom_range(79, 0) == 0);
      tick();
      vecs++; if (d_a !== exp_da)
        begin errs++; $display("FAIL rand_a i=%0d: got %h want %h", i, d_a, exp_da); end
      vecs++; if (d_b !== exp_db)
        begin errs++; $display("FAIL rand_b i=%0d: got %h want %h", i, d_b, exp_db); end
      vecs++; if (d_c !== exp_dc)
        begin errs++; $display("FAIL rand_c i=%0d: got %h want %h", i, d_c, exp_dc); end
      vecs++; if (busy_a !== (sl_ab > 0) || busy_b !== (sl_ab > 0) || busy_c !== (sl_c > 0))
        begin errs++; $display("FAIL rand_busy i=%0d: got %b%b%b", i, busy_a, busy_b, busy_c); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    r_ab  = '0;
    r_c   = '0;
    rst_n = 1'b0;
    foreach (m_ab[i]) m_ab[i] = '0;
    foreach (m_c[i])  m_c[i]  = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_same_addr();
    test_clear();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
